// File: rtl/jb_resolve_unit.sv
// rtl/jb_resolve_unit.sv - registered branch/jump resolution stage with mispredict counter
module jb_resolve_unit #(
  parameter int XLEN  = 64,
  parameter int C_EXT = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  pred_npc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [XLEN-1:0]  out_target,
  output logic [XLEN-1:0]  out_link,
  output logic [XLEN-1:0]  out_npc,
  output logic             out_mispredict,
  output logic             out_misaligned,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam logic [4:0]       OP_JAL    = 5'b11011;
  localparam logic [4:0]       OP_JALR   = 5'b11001;
  localparam logic [4:0]       OP_BRANCH = 5'b11000;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic             out_valid_q, out_valid_d;
  logic             out_taken_q, out_taken_d;
  logic [XLEN-1:0]  out_target_q, out_target_d;
  logic [XLEN-1:0]  out_link_q, out_link_d;
  logic [XLEN-1:0]  out_npc_q, out_npc_d;
  logic             out_mispredict_q, out_mispredict_d;
  logic             out_misaligned_q, out_misaligned_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic [XLEN-1:0]  pc_imm, rs1_imm, target, link, npc;
  logic             br_cond, taken, misaligned;
  logic             capture, transfer;

  always_comb begin
    pc_imm  = pc + imm;
    rs1_imm = rs1 + imm;
    link    = pc + XLEN'(4);

    unique case (funct3)
      3'b000:  br_cond = (rs1 == rs2);
      3'b001:  br_cond = (rs1 != rs2);
      3'b100:  br_cond = ($signed(rs1) < $signed(rs2));
      3'b101:  br_cond = ($signed(rs1) >= $signed(rs2));
      3'b110:  br_cond = (rs1 < rs2);
      3'b111:  br_cond = (rs1 >= rs2);
      default: br_cond = 1'b0;
    endcase

    target = pc_imm;
    taken  = 1'b0;
    unique case (opcode)
      OP_JAL:    taken = 1'b1;
      OP_JALR: begin
        taken  = 1'b1;
        target = {rs1_imm[XLEN-1:1], 1'b0};
      end
      OP_BRANCH: taken = br_cond;
      default:   taken = 1'b0;
    endcase

    // Misaligned targets still redirect; the trap is raised further down the pipe.
    npc        = taken ? target : link;
    misaligned = (C_EXT == 0) ? (taken & target[1]) : 1'b0;
  end

  always_comb begin
    in_ready = !flush && (!out_valid_q || out_ready);
    capture  = in_valid && in_ready;
    transfer = out_valid_q && out_ready && !flush;

    out_valid_d      = out_valid_q;
    out_taken_d      = out_taken_q;
    out_target_d     = out_target_q;
    out_link_d       = out_link_q;
    out_npc_d        = out_npc_q;
    out_mispredict_d = out_mispredict_q;
    out_misaligned_d = out_misaligned_q;
    mispred_cnt_d    = mispred_cnt_q;

    if (flush)         out_valid_d = 1'b0;
    else if (capture)  out_valid_d = 1'b1;
    else if (transfer) out_valid_d = 1'b0;

    if (capture) begin
      out_taken_d      = taken;
      out_target_d     = target;
      out_link_d       = link;
      out_npc_d        = npc;
      out_mispredict_d = (npc != pred_npc);
      out_misaligned_d = misaligned;
    end

    if (transfer && out_mispredict_q && (mispred_cnt_q != CNT_MAX))
      mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q      <= 1'b0;
      out_taken_q      <= 1'b0;
      out_target_q     <= '0;
      out_link_q       <= '0;
      out_npc_q        <= '0;
      out_mispredict_q <= 1'b0;
      out_misaligned_q <= 1'b0;
      mispred_cnt_q    <= '0;
    end else begin
      out_valid_q      <= out_valid_d;
      out_taken_q      <= out_taken_d;
      out_target_q     <= out_target_d;
      out_link_q       <= out_link_d;
      out_npc_q        <= out_npc_d;
      out_mispredict_q <= out_mispredict_d;
      out_misaligned_q <= out_misaligned_d;
      mispred_cnt_q    <= mispred_cnt_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_taken      = out_taken_q;
  assign out_target     = out_target_q;
  assign out_link       = out_link_q;
  assign out_npc        = out_npc_q;
  assign out_mispredict = out_mispredict_q;
  assign out_misaligned = out_misaligned_q;
  assign mispred_cnt    = mispred_cnt_q;

endmodule

// File: tb/tb_jb_resolve_unit.sv
// tb/tb_jb_resolve_unit.sv - directed self-checking bench for jb_resolve_unit
module tb_jb_resolve_unit;

  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_ALU    = 5'b01100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // 64-bit instance, 16-bit counter
  logic        a_in_valid = 0, a_in_ready, a_flush = 0, a_out_valid, a_out_ready = 1;
  logic [4:0]  a_opcode = 0;
  logic [2:0]  a_funct3 = 0;
  logic [63:0] a_pc = 0, a_rs1 = 0, a_rs2 = 0, a_imm = 0, a_pred = 0;
  logic        a_taken, a_mispredict, a_misaligned;
  logic [63:0] a_target, a_link, a_npc;
  logic [15:0] a_cnt;

  // 32-bit instance, 2-bit counter
  logic        b_in_valid = 0, b_in_ready, b_flush = 0, b_out_valid, b_out_ready = 1;
  logic [4:0]  b_opcode = 0;
  logic [2:0]  b_funct3 = 0;
  logic [31:0] b_pc = 0, b_rs1 = 0, b_rs2 = 0, b_imm = 0, b_pred = 0;
  logic        b_taken, b_mispredict, b_misaligned;
  logic [31:0] b_target, b_link, b_npc;
  logic [1:0]  b_cnt;

  jb_resolve_unit #(.XLEN(64), .C_EXT(0), .CNT_W(16)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .opcode(a_opcode), .funct3(a_funct3), .pc(a_pc), .rs1(a_rs1), .rs2(a_rs2),
    .imm(a_imm), .pred_npc(a_pred), .flush(a_flush), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_taken(a_taken), .out_target(a_target),
    .out_link(a_link), .out_npc(a_npc), .out_mispredict(a_mispredict),
    .out_misaligned(a_misaligned), .mispred_cnt(a_cnt)
  );

  jb_resolve_unit #(.XLEN(32), .C_EXT(0), .CNT_W(2)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .opcode(b_opcode), .funct3(b_funct3), .pc(b_pc), .rs1(b_rs1), .rs2(b_rs2),
    .imm(b_imm), .pred_npc(b_pred), .flush(b_flush), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_taken(b_taken), .out_target(b_target),
    .out_link(b_link), .out_npc(b_npc), .out_mispredict(b_mispredict),
    .out_misaligned(b_misaligned), .mispred_cnt(b_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [4:0] op, input logic [2:0] f3, input logic [63:0] p,
                         input logic [63:0] r1, input logic [63:0] r2, input logic [63:0] im,
                         input logic [63:0] pr);
    a_opcode = op; a_funct3 = f3; a_pc = p; a_rs1 = r1; a_rs2 = r2; a_imm = im; a_pred = pr;
  endtask

  task automatic drive_b(input logic [4:0] op, input logic [31:0] p, input logic [31:0] im,
                         input logic [31:0] pr);
    b_opcode = op; b_funct3 = 3'b000; b_pc = p; b_rs1 = 0; b_rs2 = 0; b_imm = im; b_pred = pr;
  endtask

  initial begin
    #2;
    check("rst_valid64", 64'(a_out_valid), 64'd0);
    check("rst_target64", a_target, 64'd0);
    check("rst_npc64", a_npc, 64'd0);
    check("rst_cnt64", 64'(a_cnt), 64'd0);
    check("rst_ready64", 64'(a_in_ready), 64'd1);
    check("rst_valid32", 64'(b_out_valid), 64'd0);
    #10;
    rst_n = 1'b1;
    step();

    a_in_valid = 1;
    a_out_ready = 1;
    drive_a(OP_JALR, 3'b000, 64'h2000, 64'h1001, 64'h0, 64'h4, 64'h1004);
    step();
    check("jalr_valid", 64'(a_out_valid), 64'd1);
    check("jalr_target", a_target, 64'h1004);
    check("jalr_taken", 64'(a_taken), 64'd1);
    check("jalr_link", a_link, 64'h2004);
    check("jalr_npc", a_npc, 64'h1004);
    check("jalr_mispred", 64'(a_mispredict), 64'd0);

    drive_a(OP_BRANCH, 3'b100, 64'h3000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h40, 64'h3004);
    step();
    check("blt_taken", 64'(a_taken), 64'd1);
    check("blt_npc", a_npc, 64'h3040);
    check("blt_mispred", 64'(a_mispredict), 64'd1);

    drive_a(OP_BRANCH, 3'b110, 64'h3000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h40, 64'h3004);
    step();
    check("bltu_taken", 64'(a_taken), 64'd0);
    check("bltu_npc", a_npc, 64'h3004);
    check("bltu_target", a_target, 64'h3040);
    check("bltu_mispred", 64'(a_mispredict), 64'd0);
    check("cnt_after_blt", 64'(a_cnt), 64'd1);

    drive_a(OP_BRANCH, 3'b010, 64'h6000, 64'h7, 64'h7, 64'h20, 64'h6020);
    step();
    check("f3_010_taken", 64'(a_taken), 64'd0);
    check("f3_010_npc", a_npc, 64'h6004);
    check("f3_010_mispred", 64'(a_mispredict), 64'd1);

    drive_a(OP_ALU, 3'b000, 64'h7000, 64'h0, 64'h0, 64'h8, 64'h7004);
    step();
    check("alu_taken", 64'(a_taken), 64'd0);
    check("alu_target", a_target, 64'h7008);
    check("alu_npc", a_npc, 64'h7004);
    check("cnt_after_f3", 64'(a_cnt), 64'd2);

    drive_a(OP_JALR, 3'b000, 64'h7100, 64'h100, 64'h0, 64'h6, 64'h106);
    step();
    check("jalr_mis_npc", a_npc, 64'h106);
    check("jalr_misaligned", 64'(a_misaligned), 64'd1);

    a_in_valid = 0;
    step();
    check("drain_valid", 64'(a_out_valid), 64'd0);

    a_out_ready = 0;
    a_in_valid = 1;
    drive_a(OP_JAL, 3'b000, 64'h4000, 64'h0, 64'h0, 64'h100, 64'h4100);
    step();
    check("bp_capture", a_target, 64'h4100);
    drive_a(OP_JAL, 3'b000, 64'h5000, 64'h0, 64'h0, 64'h10, 64'h0);
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", 64'(a_in_ready), 64'd0);
      check("bp_hold_target", a_target, 64'h4100);
      check("bp_hold_valid", 64'(a_out_valid), 64'd1);
      step();
    end
    a_out_ready = 1;
    #1;
    check("bp_release_ready", 64'(a_in_ready), 64'd1);
    step();
    check("bp_next_target", a_target, 64'h5010);
    check("bp_next_mispred", 64'(a_mispredict), 64'd1);
    check("bp_cnt", 64'(a_cnt), 64'd2);

    a_flush = 1;
    drive_a(OP_JAL, 3'b000, 64'h8000, 64'h0, 64'h0, 64'h4, 64'h8004);
    #1;
    check("flush_in_ready", 64'(a_in_ready), 64'd0);
    step();
    check("flush_valid", 64'(a_out_valid), 64'd0);
    check("flush_cnt", 64'(a_cnt), 64'd2);
    a_flush = 0;
    a_in_valid = 0;
    step();
    check("flush_no_capture", 64'(a_out_valid), 64'd0);
    check("flush_cnt_after", 64'(a_cnt), 64'd2);

    b_in_valid = 1;
    b_out_ready = 1;
    drive_b(OP_JAL, 32'hFFFF_FFFC, 32'h8, 32'h4);
    step();
    check("wrap_target", 64'(b_target), 64'h4);
    check("wrap_link", 64'(b_link), 64'h0);
    check("wrap_mispred", 64'(b_mispredict), 64'd0);

    drive_b(OP_JAL, 32'h100, 32'h6, 32'h106);
    step();
    check("mis32_misaligned", 64'(b_misaligned), 64'd1);
    check("mis32_npc", 64'(b_npc), 64'h106);

    drive_b(OP_JAL, 32'h200, 32'h10, 32'h0);
    step();
    check("cnt32_start", 64'(b_cnt), 64'd0);
    for (int k = 1; k <= 5; k++) begin
      step();
      check($sformatf("cnt32_%0d", k), 64'(b_cnt), (k < 3) ? 64'(k) : 64'd3);
    end

    #2;
    rst_n = 1'b0;
    #1;
    check("async_cnt", 64'(b_cnt), 64'd0);
    check("async_valid", 64'(b_out_valid), 64'd0);
    check("async_in_ready", 64'(b_in_ready), 64'd1);
    b_in_valid = 0;
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_valid", 64'(b_out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
